// File: rtl/uart_tx_sched_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
package uart_tx_sched_pkg;

  // FSM state encoding
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LAUNCH = 2'b01,
    WAIT   = 2'b10
  } state_t;

  localparam int unsigned NREQ_DEF   = 4;
  localparam int unsigned DATA_W_DEF = 8;
  // owner index width covers the full legal NREQ range (up to 8)
  localparam int unsigned OWNER_W    = 3;

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// rr_pick: combinational round-robin selector; search starts one past the last owner.
module rr_pick
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]    req,
  input  logic [OWNER_W-1:0] last,
  output logic [OWNER_W-1:0] idx,
  output logic               valid
);

  // Walk offsets 1..NREQ from the last owner; the first active request wins.
  always_comb begin
    int unsigned cand;
    logic        found;
    cand  = 0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = (32'(last) + off) % NREQ;
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!found && (j == cand) && req[j]) begin
          found = 1'b1;
          idx   = OWNER_W'(j);
        end
      end
    end
    valid = found;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter feeding a single UART transmitter.
// Optional WAIT-state watchdog enabled by defining UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned NREQ    = NREQ_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [NREQ-1:0]        i_req,
  input  logic [NREQ*DATA_W-1:0] i_data,
  output logic [NREQ-1:0]        o_grant,
  output logic                   o_tx_start,
  output logic [DATA_W-1:0]      o_tx_data,
  input  logic                   i_tx_done,
  output logic                   o_busy,
  output logic [OWNER_W-1:0]     o_owner,
  output logic                   o_timeout
);

  // Parameter sanity checks at elaboration
  if (NREQ < 2 || NREQ > 8) begin : g_nreq_chk
    $error("uart_tx_sched: NREQ must be in 2..8");
  end
  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("uart_tx_sched: TIMEOUT must be at least 1");
  end

  localparam logic [NREQ-1:0] GRANT_ONE = NREQ'(1);

  state_t               state, state_d;
  logic [NREQ-1:0]      grant_d;
  logic                 start_d;
  logic [DATA_W-1:0]    data_d;
  logic                 busy_d;
  logic [OWNER_W-1:0]   owner_d;
  logic [OWNER_W-1:0]   pick_idx;
  logic                 pick_valid;
  logic [DATA_W-1:0]    pick_data;

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wd_cnt, wd_cnt_d;
  logic             timeout_d;
`endif

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req   (i_req),
    .last  (o_owner),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Byte mux for the winning requester
  always_comb begin
    pick_data = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (pick_idx == OWNER_W'(k)) begin
        pick_data = i_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state;
    grant_d = '0;
    start_d = 1'b0;
    data_d  = o_tx_data;
    owner_d = o_owner;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    wd_cnt_d  = wd_cnt;
    timeout_d = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_d = LAUNCH;
          grant_d = GRANT_ONE << pick_idx;
          owner_d = pick_idx;
          data_d  = pick_data;
        end
      end
      LAUNCH: begin
        // i_tx_done is deliberately ignored here
        start_d = 1'b1;
        state_d = WAIT;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        wd_cnt_d = '0;
`endif
      end
      WAIT: begin
        if (i_tx_done) begin
          state_d = IDLE;
        end
`ifdef UART_TX_SCHED_TIMEOUT_EN
        // done on the limit edge wins; owner already points past the aborted frame
        else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      o_grant    <= '0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_busy     <= 1'b0;
      o_owner    <= OWNER_W'(NREQ - 1);
    end else begin
      state      <= state_d;
      o_grant    <= grant_d;
      o_tx_start <= start_d;
      o_tx_data  <= data_d;
      o_busy     <= busy_d;
      o_owner    <= owner_d;
    end
  end

`ifdef UART_TX_SCHED_TIMEOUT_EN
  // Watchdog counter and abort pulse
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wd_cnt    <= '0;
      o_timeout <= 1'b0;
    end else begin
      wd_cnt    <= wd_cnt_d;
      o_timeout <= timeout_d;
    end
  end
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched (NREQ=4, DATA_W=8); timeout cases run when
// UART_TX_SCHED_TIMEOUT_EN is defined.
module tb_uart_tx_sched;

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 4095;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [3:0]  i_req = '0;
  logic [31:0] i_data = 32'h44A5_2211;
  logic [3:0]  o_grant;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        i_tx_done = 1'b0;
  logic        o_busy;
  logic [2:0]  o_owner;
  logic        o_timeout;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_sched #(.NREQ(4), .DATA_W(8), .TIMEOUT(TO)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_req      (i_req),
    .i_data     (i_data),
    .o_grant    (o_grant),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .i_tx_done  (i_tx_done),
    .o_busy     (o_busy),
    .o_owner    (o_owner),
    .o_timeout  (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic       start;
    logic [7:0] data;
    logic       busy;
    logic [2:0] owner;
  } vec_t;

  vec_t tbl[12];
  logic [7:0] byte_of[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; drive and sample 1ns after the rising edge
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    byte_of = '{8'h11, 8'h22, 8'hA5, 8'h44};

    // cycle table: inputs applied, then outputs expected after the next edge
    tbl[0]  = '{4'b0100, 1'b0, 4'b0100, 1'b0, 8'hA5, 1'b1, 3'd2};
    tbl[1]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'hA5, 1'b1, 3'd2};
    tbl[2]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'hA5, 1'b1, 3'd2};
    tbl[3]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'hA5, 1'b0, 3'd2};
    tbl[4]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'hA5, 1'b0, 3'd2};
    tbl[5]  = '{4'b0001, 1'b0, 4'b0001, 1'b0, 8'h11, 1'b1, 3'd0};
    tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 8'h11, 1'b1, 3'd0};
    tbl[7]  = '{4'b1000, 1'b0, 4'b0000, 1'b0, 8'h11, 1'b1, 3'd0};
    tbl[8]  = '{4'b1000, 1'b1, 4'b0000, 1'b0, 8'h11, 1'b0, 3'd0};
    tbl[9]  = '{4'b1000, 1'b0, 4'b1000, 1'b0, 8'h44, 1'b1, 3'd3};
    tbl[10] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'h44, 1'b1, 3'd3};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h44, 1'b0, 3'd3};

    // reset values
    step();
    step();
    check("rst_grant", 32'(o_grant), 32'h0);
    check("rst_start", 32'(o_tx_start), 32'h0);
    check("rst_data", 32'(o_tx_data), 32'h0);
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_owner", 32'(o_owner), 32'd3);
    check("rst_timeout", 32'(o_timeout), 32'h0);
    i_reset = 1'b1;

    // table: single request, done in LAUNCH ignored, requests outside IDLE ignored
    for (int i = 0; i < 12; i++) begin
      i_req     = tbl[i].req;
      i_tx_done = tbl[i].done;
      step();
      check($sformatf("v%0d_grant", i), 32'(o_grant), 32'(tbl[i].grant));
      check($sformatf("v%0d_start", i), 32'(o_tx_start), 32'(tbl[i].start));
      check($sformatf("v%0d_data", i), 32'(o_tx_data), 32'(tbl[i].data));
      check($sformatf("v%0d_busy", i), 32'(o_busy), 32'(tbl[i].busy));
      check($sformatf("v%0d_owner", i), 32'(o_owner), 32'(tbl[i].owner));
      check($sformatf("v%0d_timeout", i), 32'(o_timeout), 32'h0);
    end
    i_tx_done = 1'b0;
    i_req     = '0;

    // fairness: all requesting, done 10 cycles after each start -> 0,1,2,3,0
    i_req = 4'hF;
    for (int f = 0; f < 5; f++) begin
      int exp_k;
      exp_k = f % 4;
      cnt = 0;
      step();
      while (o_grant == 4'b0 && cnt < 20) begin
        step();
        cnt++;
      end
      check("rr_grant_wait", 32'(cnt < 20), 32'd1);
      check($sformatf("rr%0d_grant", f), 32'(o_grant), 32'(4'b0001 << exp_k));
      check($sformatf("rr%0d_owner", f), 32'(o_owner), 32'(exp_k));
      check($sformatf("rr%0d_data", f), 32'(o_tx_data), 32'(byte_of[exp_k]));
      step();
      check($sformatf("rr%0d_start", f), 32'(o_tx_start), 32'h1);
      check($sformatf("rr%0d_onegrant", f), 32'(o_grant), 32'h0);
      for (int c = 0; c < 9; c++) step();
      check($sformatf("rr%0d_busy_wait", f), 32'(o_busy), 32'h1);
      check($sformatf("rr%0d_data_hold", f), 32'(o_tx_data), 32'(byte_of[exp_k]));
      i_tx_done = 1'b1;
      step();
      i_tx_done = 1'b0;
      check($sformatf("rr%0d_busy_done", f), 32'(o_busy), 32'h0);
    end
    i_req = '0;
    step();

    // reset asserted mid-frame in WAIT
    i_req = 4'b0010;
    step();
    check("mr_grant", 32'(o_grant), 32'b0010);
    i_req = '0;
    step();
    check("mr_start", 32'(o_tx_start), 32'h1);
    i_reset = 1'b0;
    #1;
    check("mr_busy", 32'(o_busy), 32'h0);
    check("mr_start_rst", 32'(o_tx_start), 32'h0);
    check("mr_owner", 32'(o_owner), 32'd3);
    check("mr_data", 32'(o_tx_data), 32'h0);
    i_req = 4'b0101;
    step();
    check("mr_no_grant_in_rst", 32'(o_grant), 32'h0);
    i_reset = 1'b1;
    step();
    check("mr_first_grant", 32'(o_grant), 32'b0001);
    check("mr_first_owner", 32'(o_owner), 32'd0);
    i_req = '0;
    step();
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    check("mr_done_busy", 32'(o_busy), 32'h0);

`ifdef UART_TX_SCHED_TIMEOUT_EN
    // watchdog fires 16 cycles after WAIT entry; next requester served
    i_req = 4'b0010;
    step();
    check("to_grant", 32'(o_grant), 32'b0010);
    i_req = '0;
    step();
    for (int n = 1; n <= 16; n++) begin
      step();
      if (n == 15) begin
        check("to_pre_timeout", 32'(o_timeout), 32'h0);
        check("to_pre_busy", 32'(o_busy), 32'h1);
      end
    end
    check("to_timeout", 32'(o_timeout), 32'h1);
    check("to_busy", 32'(o_busy), 32'h0);
    i_req = 4'b0111;
    step();
    check("to_pulse_once", 32'(o_timeout), 32'h0);
    check("to_next_grant", 32'(o_grant), 32'b0100);
    i_req = '0;
    step();
    // done on the limit edge wins over the watchdog
    for (int n = 1; n <= 15; n++) step();
    check("tl_pre_busy", 32'(o_busy), 32'h1);
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    check("tl_no_timeout", 32'(o_timeout), 32'h0);
    check("tl_busy", 32'(o_busy), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter DATA_W, default 8: byte width forwarded to the transmitter.
REQ-003 Parameter TIMEOUT, default 4095: WAIT-state cycle limit; used only when UART_TX_SCHED_TIMEOUT_EN is defined.
REQ-004 i_clk  in  1  rising-edge clock.
REQ-005 i_reset  in  1  asynchronous, active-low reset.
REQ-006 i_req  in  NREQ  per-requester transmit request (level).
REQ-007 i_data  in  NREQ*DATA_W  per-requester byte; requester k occupies bits [k*DATA_W +: DATA_W].
REQ-008 o_grant  out  NREQ  one-hot, one-cycle pulse: the requester's byte has been accepted.
REQ-009 o_tx_start  out  1  one-cycle start pulse to the UART transmitter.
REQ-010 o_tx_data  out  DATA_W  latched byte presented to the transmitter.
REQ-011 i_tx_done  in  1  one-cycle pulse from the transmitter: frame (stop bit) finished.
REQ-012 o_busy  out  1  high whenever the state is not IDLE.
REQ-013 o_owner  out  3  index of the current/last granted requester.
REQ-014 o_timeout  out  1  one-cycle pulse: frame aborted by the watchdog.

Function
REQ-015 The FSM SHALL have states IDLE, LAUNCH and WAIT; all outputs are registered.
REQ-016 IDLE with any i_req bit set at edge k: the FSM SHALL select the winner round-robin, starting at (last owner + 1) mod NREQ.
REQ-017 At that same edge k: the FSM SHALL latch the winner's byte into o_tx_data, pulse the winner's o_grant bit in cycle k+1, update o_owner, and move to LAUNCH.
REQ-018 In LAUNCH: o_tx_start SHALL be high for exactly one cycle, then the FSM moves to WAIT; request-to-start latency is 2 cycles.
REQ-019 In WAIT: the FSM SHALL return to IDLE on the first edge where i_tx_done=1; a new grant is possible at the next edge.
REQ-020 i_tx_done while in IDLE or LAUNCH SHALL be ignored.
REQ-021 o_tx_data SHALL stay stable from LAUNCH until the FSM returns to IDLE.
REQ-022 Requests SHALL be sampled only in IDLE; a request dropped before the grant is never served; changes to i_req or i_data outside IDLE have no effect.
REQ-023 A requester holding i_req high after its grant SHALL be treated as a new request.
REQ-024 Fairness: with all NREQ requesters continuously active, grant order SHALL be strictly cyclic; no requester waits more than NREQ-1 frames.
REQ-025 At most one o_grant bit SHALL be high in any cycle.

Reset
REQ-026 Asserting i_reset SHALL force IDLE immediately, including mid-frame.
REQ-027 Reset values: o_grant=0, o_tx_start=0, o_tx_data=0, o_busy=0, o_owner=NREQ-1 (so requester 0 wins first), o_timeout=0, watchdog counter=0.
REQ-028 After reset release, the first grant SHALL require a fresh request sampled in IDLE; no frame is resumed.

Configuration
REQ-029 Defining UART_TX_SCHED_TIMEOUT_EN SHALL add a watchdog counter that clears on WAIT entry and increments every WAIT cycle.
REQ-030 With the macro defined: if the count reaches TIMEOUT without i_tx_done, the block SHALL pulse o_timeout for one cycle, return to IDLE, and advance the round-robin pointer past the owner.
REQ-031 With the macro defined: i_tx_done on the same edge the limit is reached SHALL take priority, with no timeout.
REQ-032 Without the macro: WAIT SHALL last indefinitely, o_timeout SHALL be tied 0, and no counter logic SHALL be synthesized.

Structure
REQ-033 A shared package SHALL hold the state encoding (IDLE=2'b00, LAUNCH=2'b01, WAIT=2'b10) and the default NREQ and DATA_W constants.
REQ-034 The round-robin selector SHALL be a sub-module rr_pick: inputs request vector and last owner; outputs winner index and a valid flag; purely combinational.

Verification
REQ-035 Single request: i_req=4'b0100, i_data[23:16]=8'hA5 -> o_grant=4'b0100 one cycle; o_tx_start 2 cycles after the request edge; o_tx_data=8'hA5; o_busy=1 until i_tx_done.
REQ-036 All four requesting continuously, i_tx_done 10 cycles after each start -> grants 0,1,2,3,0; o_owner follows the same sequence.
REQ-037 i_tx_done pulsed in LAUNCH -> ignored; FSM stays in WAIT until the next i_tx_done.
REQ-038 i_reset asserted in WAIT -> o_busy=0 and o_tx_start=0 immediately; o_owner=3; after release, requests 0 and 2 both active -> requester 0 granted first.
REQ-039 With UART_TX_SCHED_TIMEOUT_EN and TIMEOUT=16, i_tx_done never pulsed -> o_timeout pulses 16 cycles after WAIT entry; FSM returns to IDLE; the next requester is granted.
REQ-040 With UART_TX_SCHED_TIMEOUT_EN, i_tx_done on the limit cycle -> o_timeout stays 0; normal completion.
